// File: rtl/max_6_0_err_monitor.sv
// max_6_0_err_monitor: windowed mismatch/Hamming/max-error monitor for the approximate max_6_0 partition.
// Define MAX_6_0_ERR_MON_MAXERR_EN to build in max-absolute-error tracking; otherwise rpt_maxerr is tied to 0.
module max_6_0_err_monitor #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16,
  parameter int THRESH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       approx,
  input  logic [3:0]       exact,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_mismatch,
  output logic [CNT_W-1:0] rpt_hamming,
  output logic [3:0]       rpt_maxerr,
  output logic             rpt_fail
);
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  state_t state;
  logic [CNT_W-1:0] sample_cnt, mismatch, hamming;
  logic [3:0] x;
  logic [2:0] pop;
  logic xfer, go;
  assign x = approx ^ exact;
  assign pop = {2'b0, x[0]} + {2'b0, x[1]} + {2'b0, x[2]} + {2'b0, x[3]};
  assign xfer = in_valid && state == ACCUM;
  assign go = start && state == IDLE;
  assign in_ready = state == ACCUM;
  assign rpt_valid = state == REPORT;
  assign rpt_mismatch = mismatch;
  assign rpt_hamming = hamming;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sample_cnt <= '0;
      mismatch <= '0;
      hamming <= '0;
      rpt_fail <= 1'b0;
    end else if (clear || go) begin
      state <= clear ? IDLE : ACCUM;
      sample_cnt <= '0;
      mismatch <= '0;
      hamming <= '0;
      rpt_fail <= 1'b0;
    end else if (xfer) begin
      sample_cnt <= sample_cnt + 1'b1;
      mismatch <= mismatch + CNT_W'(x != 4'd0);
      hamming <= hamming + CNT_W'(pop);
      // fail is registered from the post-update count so it matches the held report
      rpt_fail <= (mismatch + CNT_W'(x != 4'd0)) > CNT_W'(THRESH);
      if (sample_cnt == CNT_W'(WINDOW - 1)) state <= REPORT;
    end else if (state == REPORT && rpt_ready) begin
      state <= IDLE;
    end
`ifdef MAX_6_0_ERR_MON_MAXERR_EN
  logic [4:0] diff, neg;
  logic [3:0] abs_err;
  logic [3:0] maxerr;
  assign diff = {1'b0, approx} - {1'b0, exact};
  assign neg = -diff;
  assign abs_err = diff[4] ? neg[3:0] : diff[3:0];
  assign rpt_maxerr = maxerr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) maxerr <= 4'd0;
    else if (clear || go) maxerr <= 4'd0;
    else if (xfer && abs_err > maxerr) maxerr <= abs_err;
`else
  assign rpt_maxerr = 4'd0;
`endif
endmodule
